// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
//   state_t     : round FSM states
//   status_t    : 3-bit per-player result code
//   LFSR_SEED   : power-on value of the delay LFSR
//   LFSR_TAPS   : feedback taps (x^16+x^14+x^13+x^11, right-shifting form)
//   lfsr_next() : one LFSR step
package reaction_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

    typedef logic [2:0] status_t;
    localparam status_t ST_NONE        = 3'd0;
    localparam status_t ST_OK          = 3'd1;
    localparam status_t ST_FALSE_START = 3'd2;
    localparam status_t ST_TOO_FAST    = 3'd3;
    localparam status_t ST_NO_RESPONSE = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bits 0,2,3,5 of a right-shifting register realise x^16+x^14+x^13+x^11.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // A non-zero state never maps to zero, so the sequence can't lock up.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: pulses tick once every CLK_PER_MS cycles.
//   clock   in  system clock
//   reset   in  asynchronous active-low reset
//   restart in  synchronous restart; next tick comes CLK_PER_MS cycles later
//   tick    out 1-cycle pulse per millisecond
module ms_tick_gen #(
    parameter int CLK_PER_MS = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                        cnt <= '0;
        else if (restart || cnt == LAST)   cnt <= '0;
        else                               cnt <= cnt + CW'(1);
    end

    // A restart cycle never ticks, so the first ms after restart is full length.
    assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/multi_reaction_timer.sv
// N-player reaction-time tester.
// A start rising edge (from IDLE/DONE) arms a round: after a pseudo-random
// delay the stimulus rises and each player's first react is timed in ms.
// Reacting early is a false start; a time below MIN_REACT is too fast; no
// react within TIMEOUT ms is no-response. The fastest OK player wins.
//   clock, reset  : system clock, asynchronous active-low reset
//   start         : debounced level, rising edge arms a round
//   react         : debounced per-player level
//   stimulus      : high while measuring
//   busy          : high while armed or measuring
//   done          : 1-cycle pulse when results become final
//   t_react       : per-player time (ms), player i at [i*TIME_W +: TIME_W]
//   status        : per-player 3-bit status code
//   winner        : index of fastest OK player (lowest index on ties)
//   winner_valid  : high in DONE when at least one player is OK
// Build option BEST_TIME_EN adds best_time: per-player minimum OK time across
// rounds, all-ones after reset, updated when a round completes.
module multi_reaction_timer
    import reaction_pkg::*;
#(
    parameter int N_PLAYERS  = 4,
    parameter int CLK_PER_MS = 1000,
    parameter int TIME_W     = 14,
    parameter int MIN_DELAY  = 1000,
    parameter int RAND_W     = 11,
    parameter int MIN_REACT  = 64,
    parameter int TIMEOUT    = 10000
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                start,
    input  logic [N_PLAYERS-1:0]                                react,
    output logic                                                stimulus,
    output logic                                                busy,
    output logic                                                done,
    output logic [N_PLAYERS*TIME_W-1:0]                         t_react,
    output logic [N_PLAYERS*3-1:0]                              status,
    output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner,
    output logic                                                winner_valid
`ifdef BEST_TIME_EN
    ,
    output logic [N_PLAYERS*TIME_W-1:0]                         best_time
`endif
);
    localparam int WIN_W   = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int DLY_MAX = MIN_DELAY + (1 << RAND_W) - 1;
    // The ms counter must hold both the longest delay and TIMEOUT.
    localparam int CNT_W   = ($clog2(DLY_MAX + 1) > TIME_W) ? $clog2(DLY_MAX + 1) : TIME_W;
    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [TIME_W-1:0] MIN_REACT_C = TIME_W'(MIN_REACT);

    state_t                             state, state_nxt;
    logic [15:0]                        lfsr;
    logic                               start_q, accept, restart, tick, done_q;
    logic [CNT_W-1:0]                   ms_cnt, delay;
    logic [N_PLAYERS-1:0][TIME_W-1:0]   t_q, t_nxt;
    status_t [N_PLAYERS-1:0]            st_q, st_nxt;
    logic [N_PLAYERS-1:0]               res_nxt;
    logic [WIN_W-1:0]                   win_idx;
    logic                               win_ok;
    logic [TIME_W-1:0]                  win_t;

    // Start is only honoured from IDLE/DONE; it takes priority over react.
    assign accept  = start && !start_q && (state == IDLE || state == DONE);
    assign restart = (state_nxt != state);

    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Per-player result latches. A player with a non-NONE status is resolved
    // and ignores further reacts until the next round clears it.
    always_comb begin
        st_nxt = st_q;
        t_nxt  = t_q;
        for (int i = 0; i < N_PLAYERS; i++) begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        st_nxt[i] = ST_NONE;
                        t_nxt[i]  = '0;
                    end
                end
                ARMED: begin
                    if (react[i]) st_nxt[i] = ST_FALSE_START;
                end
                MEASURE: begin
                    if (st_q[i] == ST_NONE) begin
                        // A react in the timeout cycle still counts as a latch.
                        if (react[i]) begin
                            t_nxt[i]  = ms_cnt[TIME_W-1:0];
                            st_nxt[i] = (ms_cnt[TIME_W-1:0] >= MIN_REACT_C) ? ST_OK : ST_TOO_FAST;
                        end else if (ms_cnt == TIMEOUT_C) begin
                            t_nxt[i]  = TIME_W'(TIMEOUT);
                            st_nxt[i] = ST_NO_RESPONSE;
                        end
                    end
                end
                default: ;
            endcase
            res_nxt[i] = (st_nxt[i] != ST_NONE);
        end
    end

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state. Timeout marks every open player, so "all resolved"
    // covers both normal completion and timeout out of MEASURE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (accept) state_nxt = ARMED;
            ARMED: begin
                if (&res_nxt)             state_nxt = DONE;
                else if (ms_cnt >= delay) state_nxt = MEASURE;
            end
            MEASURE: if (&res_nxt) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fastest OK player; strict compare keeps the lowest index on ties.
    always_comb begin
        win_idx = '0;
        win_ok  = 1'b0;
        win_t   = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (st_q[i] == ST_OK && (!win_ok || t_q[i] < win_t)) begin
                win_ok  = 1'b1;
                win_t   = t_q[i];
                win_idx = WIN_W'(i);
            end
        end
    end

    // FSM: outputs
    always_comb begin
        stimulus     = (state == MEASURE);
        busy         = (state == ARMED) || (state == MEASURE);
        done         = done_q;
        winner       = (state == DONE) ? win_idx : '0;
        winner_valid = (state == DONE) && win_ok;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr    <= LFSR_SEED;
            start_q <= 1'b0;
            ms_cnt  <= '0;
            delay   <= '0;
            t_q     <= '0;
            st_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            lfsr    <= lfsr_next(lfsr);
            start_q <= start;
            t_q     <= t_nxt;
            st_q    <= st_nxt;
            done_q  <= (state_nxt == DONE) && (state != DONE);
            if (accept) delay <= CNT_W'(MIN_DELAY) + CNT_W'(lfsr[RAND_W-1:0]);
            // Cleared on every state change; saturates instead of wrapping.
            if (restart)                    ms_cnt <= '0;
            else if (tick && ms_cnt != '1)  ms_cnt <= ms_cnt + CNT_W'(1);
        end
    end

    assign t_react = t_q;
    assign status  = st_q;

`ifdef BEST_TIME_EN
    logic [N_PLAYERS-1:0][TIME_W-1:0] best_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            best_q <= '1;
        end else if (state_nxt == DONE && state != DONE) begin
            for (int i = 0; i < N_PLAYERS; i++)
                if (st_nxt[i] == ST_OK && t_nxt[i] < best_q[i]) best_q[i] <= t_nxt[i];
        end
    end

    assign best_time = best_q;
`endif

endmodule
